// File: rtl/demux_rr_scheduler.sv
// Round-robin burst scheduler that shares one demux_1_4 among four consumers.
// Optional stall-timeout abort is enabled with `define DEMUX_SCHED_TIMEOUT_EN.
module demux_rr_scheduler #(
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned CNT_W      = 3,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned TIMEOUT    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       in_valid,
    input  logic       in_data,
    output logic       in_ready,
    output logic [1:0] sel,
    output logic       d,
    output logic       demux_rst,
    output logic [3:0] grant,
    output logic       burst_done
);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

    localparam int unsigned    GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam state_t         S_AFTER  = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

    if (BURST_LEN < 1 || BURST_LEN >= (32'd1 << CNT_W) || TIMEOUT < 1) begin : g_bad_cfg
        $error("demux_rr_scheduler: invalid BURST_LEN/CNT_W/TIMEOUT combination");
    end

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
    logic [1:0]       r_last_grant, w_last_grant_nxt;
    logic [1:0]       r_sel, w_sel_nxt;
    logic             r_d, w_d_nxt;
    logic             r_demux_rst, w_demux_rst_nxt;
    logic [3:0]       r_grant, w_grant_nxt;
    logic             r_burst_done, w_burst_done_nxt;
    logic [1:0]       w_winner, w_idx;
    logic             w_found;

`ifdef DEMUX_SCHED_TIMEOUT_EN
    localparam int unsigned      STALL_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
    logic [STALL_W-1:0] r_stall, w_stall_nxt;
`endif

    // First requester at or after last_grant+1, wrapping 3 -> 0
    always_comb begin
        w_winner = r_last_grant;
        w_found  = 1'b0;
        w_idx    = r_last_grant;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_last_grant + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_last_grant_nxt = r_last_grant;
        w_sel_nxt        = r_sel;
        w_d_nxt          = r_d;
        w_demux_rst_nxt  = r_demux_rst;
        w_grant_nxt      = r_grant;
        w_burst_done_nxt = 1'b0;
`ifdef DEMUX_SCHED_TIMEOUT_EN
        w_stall_nxt      = r_stall;
`endif
        case (r_state)
            S_IDLE: begin
                w_d_nxt         = 1'b0;
                w_demux_rst_nxt = 1'b1;
                w_grant_nxt     = 4'b0000;
                if (w_found) begin
                    w_grant_nxt      = 4'b0001 << w_winner;
                    w_sel_nxt        = w_winner;
                    w_last_grant_nxt = w_winner;
                    w_cnt_nxt        = '0;
                    w_demux_rst_nxt  = 1'b0;
                    w_state_nxt      = S_BURST;
`ifdef DEMUX_SCHED_TIMEOUT_EN
                    w_stall_nxt      = '0;
`endif
                end
            end
            S_BURST: begin
                if (in_valid) begin
                    w_d_nxt = in_data;
`ifdef DEMUX_SCHED_TIMEOUT_EN
                    w_stall_nxt = '0;
`endif
                    if (r_cnt == CNT_LAST) begin
                        // Last bit stays on the demux for one cycle before it is cleared
                        w_burst_done_nxt = 1'b1;
                        w_grant_nxt      = 4'b0000;
                        w_cnt_nxt        = '0;
                        w_gap_cnt_nxt    = '0;
                        w_state_nxt      = S_AFTER;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
`ifdef DEMUX_SCHED_TIMEOUT_EN
                else if (r_stall == STALL_LAST) begin
                    w_grant_nxt     = 4'b0000;
                    w_d_nxt         = 1'b0;
                    w_demux_rst_nxt = 1'b1;
                    w_cnt_nxt       = '0;
                    w_gap_cnt_nxt   = '0;
                    w_stall_nxt     = '0;
                    w_state_nxt     = S_AFTER;
                end else begin
                    w_stall_nxt = r_stall + STALL_W'(1);
                end
`endif
            end
            S_GAP: begin
                w_d_nxt         = 1'b0;
                w_demux_rst_nxt = 1'b1;
                w_grant_nxt     = 4'b0000;
                if (32'(r_gap_cnt) + 32'd1 >= GAP_CYCLES) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_gap_cnt    <= '0;
            r_last_grant <= 2'd3;
            r_sel        <= 2'd0;
            r_d          <= 1'b0;
            r_demux_rst  <= 1'b1;
            r_grant      <= 4'b0000;
            r_burst_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_sel        <= w_sel_nxt;
            r_d          <= w_d_nxt;
            r_demux_rst  <= w_demux_rst_nxt;
            r_grant      <= w_grant_nxt;
            r_burst_done <= w_burst_done_nxt;
        end
    end

`ifdef DEMUX_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_stall <= '0;
        else      r_stall <= w_stall_nxt;
    end
`endif

    assign in_ready   = (r_state == S_BURST);
    assign sel        = r_sel;
    assign d          = r_d;
    assign demux_rst  = r_demux_rst;
    assign grant      = r_grant;
    assign burst_done = r_burst_done;

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Self-checking bench for demux_rr_scheduler: vector table with scoreboard queue
// plus hand-written sequences for reset mid-burst and the optional timeout.
module tb_demux_rr_scheduler;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       d;
        logic       drst;
        logic       rdy;
        logic       bd;
    } out_t;

    typedef struct {
        logic       rst_first;
        int         test_id;
        logic [3:0] req;
        logic       v;
        logic       data;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       in_valid;
    logic       in_data;
    logic       in_ready;
    logic [1:0] sel;
    logic       d;
    logic       demux_rst;
    logic [3:0] grant;
    logic       burst_done;

    int checks = 0;
    int errors = 0;
    out_t  exp_q[$];
    string name_q[$];
    vec_t  tbl[$];

    always #5 clk = ~clk;

    demux_rr_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .sel        (sel),
        .d          (d),
        .demux_rst  (demux_rst),
        .grant      (grant),
        .burst_done (burst_done)
    );

    function automatic out_t o(logic [3:0] g, logic [1:0] s, logic dd, logic r, logic rd, logic b);
        out_t x;
        x.grant = g; x.sel = s; x.d = dd; x.drst = r; x.rdy = rd; x.bd = b;
        return x;
    endfunction

    function automatic out_t rst_out();
        return o(4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    endfunction

    task automatic check(input string nm, input out_t exp);
        out_t act;
        act = {grant, sel, d, demux_rst, in_ready, burst_done};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got grant=%b sel=%0d d=%b demux_rst=%b in_ready=%b burst_done=%b, expected grant=%b sel=%0d d=%b demux_rst=%b in_ready=%b burst_done=%b",
                     nm, act.grant, act.sel, act.d, act.drst, act.rdy, act.bd,
                     exp.grant, exp.sel, exp.d, exp.drst, exp.rdy, exp.bd);
        end
    endtask

    // Entered and left at posedge+1
    task automatic do_reset();
        rst = 1'b0; req = 4'b0000; in_valid = 1'b0; in_data = 1'b0;
        #2;
        check("reset", rst_out());
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic step(input string nm, input logic [3:0] r, input logic v, input logic dat, input out_t exp);
        out_t  e;
        string n;
        req = r; in_valid = v; in_data = dat;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, e);
    endtask

    task automatic add(input logic rf, input int id, input logic [3:0] r, input logic v, input logic dat, input out_t exp);
        vec_t x;
        x.rst_first = rf; x.test_id = id; x.req = r; x.v = v; x.data = dat; x.exp = exp;
        tbl.push_back(x);
    endtask

    initial begin
        logic [3:0] oh;
        logic       bit_v;
        rst = 1'b1; req = 4'b0000; in_valid = 1'b0; in_data = 1'b0;
        #1;

        // Test 1: single requester 2, bits 1,0,1,1
        add(1, 1, 4'b0100, 1, 1, o(4'b0100, 2, 0, 0, 1, 0));
        add(0, 1, 4'b0100, 1, 1, o(4'b0100, 2, 1, 0, 1, 0));
        add(0, 1, 4'b0100, 1, 0, o(4'b0100, 2, 0, 0, 1, 0));
        add(0, 1, 4'b0100, 1, 1, o(4'b0100, 2, 1, 0, 1, 0));
        add(0, 1, 4'b0100, 1, 1, o(4'b0000, 2, 1, 0, 0, 1));
        add(0, 1, 4'b0000, 0, 0, o(4'b0000, 2, 0, 1, 0, 0));
        add(0, 1, 4'b0000, 0, 0, o(4'b0000, 2, 0, 1, 0, 0));

        // Test 2: all requesting, rotation 0,1,2,3,0 with period 6
        for (int g = 0; g < 5; g++) begin
            oh = 4'b0001 << (g % 4);
            add(g == 0, 2, 4'b1111, 1, 0, o(oh, 2'(g % 4), 0, 0, 1, 0));
            for (int k = 1; k <= 4; k++) begin
                bit_v = 1'(g + k);
                if (k < 4) add(0, 2, 4'b1111, 1, bit_v, o(oh, 2'(g % 4), bit_v, 0, 1, 0));
                else       add(0, 2, 4'b1111, 1, bit_v, o(4'b0000, 2'(g % 4), bit_v, 0, 0, 1));
            end
            add(0, 2, 4'b1111, 1, 1, o(4'b0000, 2'(g % 4), 0, 1, 0, 0));
        end

        // Test 3: requester 1, 3-cycle stall after 2nd bit
        add(1, 3, 4'b0010, 1, 0, o(4'b0010, 1, 0, 0, 1, 0));
        add(0, 3, 4'b0010, 1, 0, o(4'b0010, 1, 0, 0, 1, 0));
        add(0, 3, 4'b0010, 1, 1, o(4'b0010, 1, 1, 0, 1, 0));
        for (int k = 0; k < 3; k++) add(0, 3, 4'b0010, 0, 0, o(4'b0010, 1, 1, 0, 1, 0));
        add(0, 3, 4'b0010, 1, 1, o(4'b0010, 1, 1, 0, 1, 0));
        add(0, 3, 4'b0010, 1, 0, o(4'b0000, 1, 0, 0, 0, 1));
        add(0, 3, 4'b0000, 0, 0, o(4'b0000, 1, 0, 1, 0, 0));

        // Test 5: req dropped after first transfer
        add(1, 5, 4'b0001, 1, 0, o(4'b0001, 0, 0, 0, 1, 0));
        add(0, 5, 4'b0001, 1, 1, o(4'b0001, 0, 1, 0, 1, 0));
        add(0, 5, 4'b0000, 1, 1, o(4'b0001, 0, 1, 0, 1, 0));
        add(0, 5, 4'b0000, 1, 0, o(4'b0001, 0, 0, 0, 1, 0));
        add(0, 5, 4'b0000, 1, 1, o(4'b0000, 0, 1, 0, 0, 1));
        for (int k = 0; k < 3; k++) add(0, 5, 4'b0000, 1, 1, o(4'b0000, 0, 0, 1, 0, 0));

        foreach (tbl[i]) begin
            if (tbl[i].rst_first) do_reset();
            step($sformatf("t%0d_v%0d", tbl[i].test_id, i), tbl[i].req, tbl[i].v, tbl[i].data, tbl[i].exp);
        end

        // Test 4: asynchronous reset mid-burst after two bits
        do_reset();
        step("t4_grant", 4'b1111, 1, 1, o(4'b0001, 0, 0, 0, 1, 0));
        step("t4_bit1",  4'b1111, 1, 1, o(4'b0001, 0, 1, 0, 1, 0));
        step("t4_bit2",  4'b1111, 1, 1, o(4'b0001, 0, 1, 0, 1, 0));
        rst = 1'b0;
        #2;
        check("t4_async_rst", rst_out());
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("t4_rst_hold", rst_out());
        end
        rst = 1'b1;
        step("t4_regrant0", 4'b1111, 1, 0, o(4'b0001, 0, 0, 0, 1, 0));

`ifdef DEMUX_SCHED_TIMEOUT_EN
        // Test 6: stall timeout aborts the burst and passes the turn on
        do_reset();
        step("t6_grant", 4'b1111, 1, 1, o(4'b0001, 0, 0, 0, 1, 0));
        step("t6_bit1",  4'b1111, 1, 1, o(4'b0001, 0, 1, 0, 1, 0));
        for (int k = 0; k < 7; k++) step("t6_stall", 4'b1111, 0, 0, o(4'b0001, 0, 1, 0, 1, 0));
        step("t6_abort", 4'b1111, 0, 0, o(4'b0000, 0, 0, 1, 0, 0));
        step("t6_gap",   4'b1111, 0, 0, o(4'b0000, 0, 0, 1, 0, 0));
        step("t6_next",  4'b1111, 1, 0, o(4'b0010, 1, 0, 0, 1, 0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
